// File: rtl/egg_timer_countdown.sv
// egg_timer_countdown: programmable countdown stage fed by the preset
// generator's one-cycle start pulse. Counts a 7-bit preset down to zero,
// pulses `expired`, then holds `alarm` for ALARM_CYCLES cycles before idling.
// Pause, abort and start-while-busy (overrun) handling are included.
//
// Optional feature macro: EGG_TIMER_PRESCALE_EN
//   defined   -> a clog2(PRESCALE)-bit prescaler gives one tick per PRESCALE cycles
//   undefined -> every RUN cycle is a tick and PRESCALE has no effect
//
// Handshake: `start` is a one-cycle pulse with no backpressure. It is accepted
// (and `preset` sampled) only in IDLE or ALARM; in RUN/PAUSED it is dropped
// and recorded in the sticky `overrun` flag, which only reset_n clears.
module egg_timer_countdown #(
    parameter int WIDTH        = 7,
    parameter int PRESCALE     = 4,
    parameter int ALARM_CYCLES = 3
) (
    input  logic             sysclk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] preset,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             expired,
    output logic             alarm,
    output logic             overrun
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_PAUSED = 2'd2;
    localparam logic [1:0] ST_ALARM  = 2'd3;

    localparam int AW = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
    localparam logic [AW-1:0] ALARM_LOAD = AW'(ALARM_CYCLES - 1);

    // Current FSM state; kept as a plainly named register so checkers can bind to it.
    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [WIDTH-1:0] count_nx;
    logic             expired_nx;
    logic             overrun_nx;
    logic [AW-1:0]    alarm_cnt;
    logic [AW-1:0]    alarm_cnt_nx;
    logic             tick;
    logic             load;
    logic             run_step;

`ifdef EGG_TIMER_PRESCALE_EN
    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PSC_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0] psc;
    logic [PW-1:0] psc_nx;

    assign tick = (psc == PSC_MAX);

    // Prescaler: cleared on load/abort, advances only on RUN cycles, wraps at PRESCALE-1.
    always_comb begin
        psc_nx = psc;
        if (abort || load) begin
            psc_nx = '0;
        end else if (run_step) begin
            psc_nx = (psc == PSC_MAX) ? '0 : psc + PW'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            psc <= '0;
        end else begin
            psc <= psc_nx;
        end
    end
`else
    // PRESCALE has no effect without the prescaler; fold it into a dummy net.
    logic unused_prescale;
    assign unused_prescale = (PRESCALE > 1);
    assign tick = 1'b1;
`endif

    assign busy = (state == ST_RUN) || (state == ST_PAUSED);

    // Next-state logic with priority abort > start > pause > tick.
    always_comb begin
        state_nx     = state;
        count_nx     = count;
        expired_nx   = 1'b0;
        overrun_nx   = overrun;
        alarm_cnt_nx = alarm_cnt;
        load         = 1'b0;
        run_step     = 1'b0;
        if (abort) begin
            state_nx     = ST_IDLE;
            count_nx     = '0;
            alarm_cnt_nx = '0;
        end else if (start && !busy) begin
            load     = 1'b1;
            count_nx = preset;
            if (preset != '0) begin
                state_nx = ST_RUN;
            end else begin
                state_nx     = ST_ALARM;
                expired_nx   = 1'b1;
                alarm_cnt_nx = ALARM_LOAD;
            end
        end else begin
            if (start) begin
                overrun_nx = 1'b1;
            end
            case (state)
                ST_RUN: begin
                    if (pause) begin
                        state_nx = ST_PAUSED;
                    end else begin
                        run_step = 1'b1;
                        if (tick) begin
                            if (count == WIDTH'(1)) begin
                                count_nx     = '0;
                                state_nx     = ST_ALARM;
                                expired_nx   = 1'b1;
                                alarm_cnt_nx = ALARM_LOAD;
                            end else if (count != '0) begin
                                count_nx = count - WIDTH'(1);
                            end
                        end
                    end
                end
                ST_PAUSED: begin
                    if (!pause) begin
                        state_nx = ST_RUN;
                    end
                end
                ST_ALARM: begin
                    if (alarm_cnt == '0) begin
                        state_nx = ST_IDLE;
                    end else begin
                        alarm_cnt_nx = alarm_cnt - AW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            count     <= '0;
            expired   <= 1'b0;
            alarm     <= 1'b0;
            overrun   <= 1'b0;
            alarm_cnt <= '0;
        end else begin
            state     <= state_nx;
            count     <= count_nx;
            expired   <= expired_nx;
            alarm     <= (state_nx == ST_ALARM);
            overrun   <= overrun_nx;
            alarm_cnt <= alarm_cnt_nx;
        end
    end

endmodule
